// File: rtl/pc_sequencer.sv
// Fetch-stage controller: owns the PC, sequences FETCH/EXEC per instruction,
// selects the next-PC mux source and traps to HALT on misalignment or halt request.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic        branch_taken,
  input  logic        halt_req,
  output logic [1:0]  pc_src,
  input  logic [31:0] pc_next,
  output logic [31:0] pc,
  output logic [31:0] retired,
  output logic        halted,
  output logic        misalign,
  output logic [1:0]  state_dbg
);

  // Fetch handshake: a word transfers on any cycle where imem_req and
  // imem_ready are both high; imem_ready is ignored while imem_req is low.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t state, state_next;
  logic   misaligned;
  logic   retire;
  logic   advance_pc;

  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    pc_src      = 2'b00;
    misaligned  = 1'b0;
    retire      = 1'b0;
    advance_pc  = 1'b0;
    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_next = S_EXEC;
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        if (is_jalr)                       pc_src = 2'b11;
        else if (is_jal)                   pc_src = 2'b10;
        else if (is_branch && branch_taken) pc_src = 2'b01;
        // Sequential pc+4 targets are never alignment-checked.
        misaligned = (pc_src != 2'b00) && (pc_next[1:0] != 2'b00);
        if (misaligned) begin
          state_next = S_HALT;
        end else if (halt_req) begin
          retire     = 1'b1;
          state_next = S_HALT;
        end else begin
          retire     = 1'b1;
          advance_pc = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      instr    <= NOP;
      retired  <= 32'd0;
      misalign <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_FETCH && imem_ready) instr <= imem_rdata;
      if (advance_pc) pc <= pc_next;
      if (retire) retired <= retired + 32'd1;
      if (misaligned) misalign <= 1'b1;
    end
  end

  assign imem_addr = pc;
  assign halted    = (state == S_HALT);
  assign state_dbg = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: sequential fetch, branches,
// jump priority, wait states, misalign trap, halt request and async reset.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        is_branch, is_jal, is_jalr, branch_taken, halt_req;
  logic [1:0]  pc_src;
  logic [31:0] pc_next;
  logic [31:0] pc;
  logic [31:0] retired;
  logic        halted;
  logic        misalign;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .branch_taken(branch_taken), .halt_req(halt_req),
    .pc_src(pc_src), .pc_next(pc_next), .pc(pc),
    .retired(retired), .halted(halted), .misalign(misalign),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_instr"}, instr, 32'h0000_0013);
    check({tag, "_retired"}, retired, 32'd0);
    check({tag, "_misalign"}, {31'd0, misalign}, 32'd0);
    check({tag, "_imem_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, "_instr_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_pc_src"}, {30'd0, pc_src}, 32'd0);
    check({tag, "_halted"}, {31'd0, halted}, 32'd0);
  endtask

  task automatic clear_flags();
    is_branch = 0; is_jal = 0; is_jalr = 0; branch_taken = 0; halt_req = 0;
  endtask

  initial begin
    rst_n = 0; imem_ready = 0; imem_rdata = 32'h0; pc_next = 32'h0;
    clear_flags();
    tick(); tick();
    check_reset_outputs("reset");

    // Sequential run with zero-wait memory
    rst_n = 1; imem_ready = 1; imem_rdata = 32'hAAAA_0001;
    check("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("f0_req", {31'd0, imem_req}, 32'd1);
    check("f0_addr", imem_addr, 32'h0);
    tick();
    check("e0_valid", {31'd0, instr_valid}, 32'd1);
    check("e0_instr", instr, 32'hAAAA_0001);
    check("e0_src", {30'd0, pc_src}, 32'd0);
    pc_next = 32'h4; imem_rdata = 32'hAAAA_0002;
    tick();
    check("f1_addr", imem_addr, 32'h4);
    check("f1_retired", retired, 32'd1);
    check("f1_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check("e1_instr", instr, 32'hAAAA_0002);
    check("e1_src", {30'd0, pc_src}, 32'd0);
    pc_next = 32'h8;
    tick();
    check("f2_addr", imem_addr, 32'h8);
    tick();
    pc_next = 32'hC;
    tick();
    check("f3_pc", pc, 32'hC);
    check("f3_retired", retired, 32'd3);

    // Taken branch; flags set during FETCH must be ignored there
    is_branch = 1; branch_taken = 1; pc_next = 32'h20;
    check("fetch_ignores_flags", {30'd0, pc_src}, 32'd0);
    tick();
    check("br_taken_src", {30'd0, pc_src}, 32'd1);
    tick();
    check("br_taken_addr", imem_addr, 32'h20);
    check("br_taken_retired", retired, 32'd4);

    // Not-taken branch
    branch_taken = 0; pc_next = 32'h24;
    tick();
    check("br_not_taken_src", {30'd0, pc_src}, 32'd0);
    tick();
    check("br_not_taken_pc", pc, 32'h24);

    // jal and jalr together: jalr wins
    clear_flags(); is_jal = 1; is_jalr = 1; pc_next = 32'h80;
    tick();
    check("jal_jalr_src", {30'd0, pc_src}, 32'd3);
    tick();
    check("jal_jalr_pc", pc, 32'h80);
    check("jal_jalr_retired", retired, 32'd6);

    // Three wait cycles in FETCH
    clear_flags(); imem_ready = 0; imem_rdata = 32'hBBBB_0003;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_pc", pc, 32'h80);
      check("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ready = 1;
    tick();
    check("post_wait_valid", {31'd0, instr_valid}, 32'd1);
    check("post_wait_instr", instr, 32'hBBBB_0003);
    pc_next = 32'h84;
    tick();
    check("post_wait_pc", pc, 32'h84);
    check("post_wait_retired", retired, 32'd7);

    // Misaligned jal target; misalign outranks halt_req
    is_jal = 1; halt_req = 1; pc_next = 32'h42;
    tick();
    check("mis_src", {30'd0, pc_src}, 32'd2);
    tick();
    check("mis_flag", {31'd0, misalign}, 32'd1);
    check("mis_halted", {31'd0, halted}, 32'd1);
    check("mis_pc", pc, 32'h84);
    check("mis_retired", retired, 32'd7);
    check("mis_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("halt_stays", {31'd0, halted}, 32'd1);
    check("halt_src", {30'd0, pc_src}, 32'd0);
    check("halt_req_low", {31'd0, imem_req}, 32'd0);

    // Asynchronous reset out of HALT
    #2 rst_n = 0;
    #1 check_reset_outputs("rst_from_mis");

    // halt_req with an aligned taken branch
    clear_flags();
    tick();
    rst_n = 1;
    tick();
    tick();
    is_branch = 1; branch_taken = 1; halt_req = 1; pc_next = 32'h40;
    check("hreq_valid", {31'd0, instr_valid}, 32'd1);
    tick();
    check("hreq_halted", {31'd0, halted}, 32'd1);
    check("hreq_retired", retired, 32'd1);
    check("hreq_pc", pc, 32'h0);
    check("hreq_misalign", {31'd0, misalign}, 32'd0);
    #2 rst_n = 0;
    #1 check_reset_outputs("rst_mid_halt");

    // Reset asserted mid-EXEC must discard the pending update
    clear_flags();
    tick();
    rst_n = 1;
    tick();
    tick();
    pc_next = 32'h100;
    check("exec_before_rst", {31'd0, instr_valid}, 32'd1);
    #2 rst_n = 0;
    #1 check_reset_outputs("rst_mid_exec");
    tick();
    check("rst_held_pc", pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: observed no finish expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage controller that owns the architectural PC register and drives the select of the next-PC multiplexer. Sequences each instruction through fetch (instruction-memory request/ready handshake) and execute (one-cycle control-flow resolution). Generates `pc_src` from decode and branch-compare inputs, registers the mux output `pc_next` as the new PC, and traps to a halted state on a misaligned target or a halt request. Sits between the instruction memory, the decoder/branch unit, and the next-PC mux.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; always equals `pc`.
- `imem_ready`  in  1  memory has valid `imem_rdata` this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  latched instruction for decode.
- `instr_valid`  out  1  high exactly in EXEC cycles.
- `is_branch`, `is_jal`, `is_jalr`  in  1 each  decode flags, sampled only in EXEC.
- `branch_taken`  in  1  branch comparator result, sampled only in EXEC.
- `halt_req`  in  1  ecall/ebreak decoded, sampled only in EXEC.
- `pc_src`  out  2  select to next-PC mux: 00 pc+4, 01 branch, 10 jal, 11 jalr.
- `pc_next`  in  32  next-PC mux output.
- `pc`  out  32  current PC register.
- `retired`  out  32  retired-instruction counter.
- `halted`  out  1  core stopped.
- `misalign`  out  1  sticky: halt caused by misaligned target.

## Operation
- FSM states: IDLE, FETCH, EXEC, HALT.
- IDLE: entered on reset; unconditionally -> FETCH on next edge.
- FETCH: `imem_req`=1. On `imem_ready`=1: `instr` <= `imem_rdata`, -> EXEC. Otherwise stay; `pc` and `instr` hold.
- EXEC: `instr_valid`=1. `pc_src` combinational, priority: `is_jalr` 11 > `is_jal` 10 > (`is_branch` & `branch_taken`) 01 > 00. `is_branch` with `branch_taken`=0 gives 00.
- EXEC, `pc_src`!=00 and `pc_next[1:0]`!=00: misaligned; `pc` holds, `retired` holds, `misalign`<=1, -> HALT.
- EXEC, `halt_req`=1 (no misalign): `retired`+1, `pc` holds, -> HALT. Misalign takes priority over `halt_req`.
- EXEC otherwise: `pc` <= `pc_next`, `retired` <= `retired`+1 (wraps 32'hFFFF_FFFF -> 0), -> FETCH.
- HALT: `halted`=1, `imem_req`=0, `pc_src`=00; leaves only via reset.
- Outside EXEC: `pc_src`=00, `instr_valid`=0; decode, branch and halt inputs ignored.
- Decode flags combining `is_jal`, `is_jalr` and `is_branch` in the same cycle resolve by the priority above.
- `pc_next` with `pc_src`=00 is not alignment-checked.

## Timing
- Reset values (async): state IDLE, `pc`=`RESET_PC`, `instr`=32'h0000_0013 (NOP), `retired`=0, `misalign`=0; outputs `imem_req`=0, `instr_valid`=0, `pc_src`=00, `halted`=0.
- Reset asserted mid-FETCH or mid-EXEC aborts immediately; no PC or counter update happens on that edge.
- Minimum 3 cycles from reset release to the first EXEC: IDLE, FETCH with `imem_ready`=1, EXEC.
- Steady state: 2 cycles per instruction with zero-wait memory; each wait cycle adds 1.
- `pc`, `retired`, `instr` and state update on the rising edge ending the cycle. `imem_addr` and `pc_src` are valid in the same cycle as the state that drives them.
- `halted` is a registered state decode: high the cycle after the trapping EXEC.

## Test plan
- Reset with `RESET_PC`=0, `imem_ready` tied 1, all flags 0 -> `imem_addr` sequence 0, 4, 8; `retired`=3 after 3 EXEC cycles; `pc_src`=00 throughout.
- EXEC with `is_branch`=1, `branch_taken`=1, `pc_next`=0x20 -> `pc_src`=01, next fetch at 0x20. Repeat with `branch_taken`=0 -> `pc_src`=00.
- EXEC with `is_jal`=1 and `is_jalr`=1 together, `pc_next`=0x80 -> `pc_src`=11, `pc`=0x80.
- `imem_ready` held low 3 cycles in FETCH -> `imem_req` stays 1, `pc` holds, `instr_valid` stays 0; EXEC follows the cycle after `imem_ready` rises.
- EXEC with `is_jal`=1, `pc_next`=0x42 -> `misalign`=1, `halted`=1, `pc` unchanged, `retired` unchanged, `imem_req`=0 thereafter.
- `halt_req` in EXEC -> `retired`+1, `halted`=1. Then assert `rst_n`=0 mid-HALT -> all outputs return to their reset values asynchronously.
